pipelined_addsub: RTL



---
 rtl/addsub_pkg.sv | 27 ++
 rtl/pipelined_addsub_adder_slice.sv | 33 +++
 rtl/pipelined_addsub.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//
// Contents:
//   slice_width()  - width of one carry-chain slice (one slice per stage)
//   stage_ctl_t    - per-stage control record {valid, carry}; the data half of
//                    each stage record (partial sum, remaining A, remaining B)
//                    changes width from stage to stage, so it is declared inside
//                    the stage generate block of the top
//   ovf()          - signed-overflow rule on the operand/result MSBs

package addsub_pkg;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   // Overflow when both addends share a sign and the result sign differs.
   function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/pipelined_addsub_adder_slice.sv
// Combinational SW-bit ripple-carry adder used as one slice of the pipelined
// carry chain.
//
// Ports:
//   a, b  in  SW  slice operands
//   cin   in  1   carry into bit 0
//   sum   out SW  slice sum
//   cout  out 1   carry out of bit SW-1

module adder_slice
   import addsub_pkg::*;
#(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
);

   always_comb begin : ripple
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < SW; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with carry/borrow-in and valid/ready
// handshakes. The carry chain is cut into STAGES slices of SW bits; stage k adds
// slice k and registers the finished low result bits, its carry-out and the
// operand bits that are still to be added. Latency STAGES, throughput 1/cycle.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   flush_i      in   synchronous flush of all in-flight operations
//   in_valid_i   in   operands valid
//   in_ready_o   out  operands accepted this cycle (when in_valid_i)
//   a_i, b_i     in   operands
//   sub_i        in   0: a+b+carry_i   1: a-b-carry_i (borrow semantics)
//   carry_i      in   carry-in / borrow-in
//   out_valid_o  out  result valid
//   out_ready_i  in   downstream accepts result
//   sum_o        out  result modulo 2^WIDTH
//   carry_o      out  MSB carry-out (subtract: 1 = no borrow)
//   overflow_o   out  signed overflow
//   zero_o       out  sum_o == 0, qualified by out_valid_o

module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             carry_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o
);

   localparam int SW = slice_width(WIDTH, STAGES);

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Global stall: the whole pipe moves only when the output slot can drain.
   assign adv        = out_ready_i | ~out_valid_o;
   assign in_ready_o = adv;

   // Subtraction as a + ~b + ~borrow.
   assign b_eff = sub_i ? ~b_i : b_i;
   assign c0    = carry_i ^ sub_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO_W  = (k + 1) * SW;   // result bits complete after this stage
      localparam int REM_W = WIDTH - LO_W;   // operand bits still to be added

      logic [SW-1:0]   a_sl;
      logic [SW-1:0]   b_sl;
      logic [SW-1:0]   s_sl;
      logic            c_in;
      logic            c_out;
      logic            valid_in;
      logic [LO_W-1:0] sum_nxt;
      logic [LO_W-1:0] sum_q;
      stage_ctl_t      ctl_q;
      logic            valid_q;
      logic            carry_q;

      assign valid_q = ctl_q.valid;
      assign carry_q = ctl_q.carry;

      if (k == 0) begin : g_src
         assign a_sl     = a_i[SW-1:0];
         assign b_sl     = b_eff[SW-1:0];
         assign c_in     = c0;
         assign valid_in = in_valid_i;
         assign sum_nxt  = s_sl;
      end else begin : g_src
         assign a_sl     = g_stage[k-1].g_rem.a_rem[SW-1:0];
         assign b_sl     = g_stage[k-1].g_rem.b_rem[SW-1:0];
         assign c_in     = g_stage[k-1].carry_q;
         assign valid_in = g_stage[k-1].valid_q;
         assign sum_nxt  = {s_sl, g_stage[k-1].sum_q};
      end

      adder_slice #(
         .SW(SW)
      ) u_slice (
         .a    (a_sl),
         .b    (b_sl),
         .cin  (c_in),
         .sum  (s_sl),
         .cout (c_out)
      );

      // Data is loaded on every advance; only the valid bit is affected by a
      // flush, so stale data may remain behind a cleared valid.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ctl_q <= '0;
            sum_q <= '0;
         end else begin
            if (flush_i) begin
               ctl_q.valid <= 1'b0;
            end else if (adv) begin
               ctl_q.valid <= valid_in;
            end
            if (adv) begin
               ctl_q.carry <= c_out;
               sum_q       <= sum_nxt;
            end
         end
      end

      // Upper operand slices travel with the operation, shrinking by one
      // slice per stage; the last stage has nothing left to carry.
      if (REM_W > 0) begin : g_rem
         logic [REM_W-1:0] a_nxt;
         logic [REM_W-1:0] b_nxt;
         logic [REM_W-1:0] a_rem;
         logic [REM_W-1:0] b_rem;

         if (k == 0) begin : g_src
            assign a_nxt = a_i[WIDTH-1:SW];
            assign b_nxt = b_eff[WIDTH-1:SW];
         end else begin : g_src
            assign a_nxt = g_stage[k-1].g_rem.a_rem[WIDTH-k*SW-1:SW];
            assign b_nxt = g_stage[k-1].g_rem.b_rem[WIDTH-k*SW-1:SW];
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               a_rem <= '0;
               b_rem <= '0;
            end else if (adv) begin
               a_rem <= a_nxt;
               b_rem <= b_nxt;
            end
         end
      end

      // The final slice holds the operand MSBs, so overflow is resolved here.
      if (k == STAGES - 1) begin : g_last
         logic ovf_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf(a_sl[SW-1], b_sl[SW-1], s_sl[SW-1]);
            end
         end
      end
   end

   assign out_valid_o = g_stage[STAGES-1].valid_q;
   assign sum_o       = g_stage[STAGES-1].sum_q;
   assign carry_o     = g_stage[STAGES-1].carry_q;
   assign overflow_o  = g_stage[STAGES-1].g_last.ovf_q;
   assign zero_o      = out_valid_o & ~|sum_o;

endmodule
